// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache/memory port arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D} arb_owner_t;

  typedef logic [19:1] word_addr_t;

  localparam int ARB_LINE_WORDS_DEFAULT = 8;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one 16-bit memory port between the I-cache backend (line-locked bursts) and the data port.
// Optional feature macro: ICACHE_COHERENCE_INVAL_EN (registered I-cache invalidate pulse per acked data write).
//
// state       | meaning
// ARB_IDLE    | no owner; grant decided here, round-robin on ties
// ARB_GRANT_I | I-cache owns the port; held for LINE_WORDS acks when bursting
// ARB_GRANT_D | data port owns the port for a single word
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int LINE_WORDS = ARB_LINE_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  word_addr_t  i_m_addr,
  input  logic        i_m_access,
  input  logic        i_line_fill,
  output logic [15:0] i_m_data_in,
  output logic        i_m_ack,
  input  word_addr_t  d_m_addr,
  input  logic [15:0] d_m_data_out,
  input  logic        d_m_wr_en,
  input  logic [1:0]  d_m_bytesel,
  input  logic        d_m_access,
  output logic [15:0] d_m_data_in,
  output logic        d_m_ack,
  output word_addr_t  q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_m_access,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in,
  output logic        inval_valid,
  output word_addr_t  inval_addr
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  arb_owner_t owner, owner_nxt;
  arb_owner_t last_owner, last_owner_nxt;
  logic burst, burst_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= ARB_IDLE;
      last_owner <= ARB_GRANT_D;
      burst      <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst      <= burst_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Leaving a grant always passes through IDLE, which enforces the one-cycle gap between grants.
  always_comb begin
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_nxt      = burst;
    burst_cnt_nxt  = burst_cnt;
    case (owner)
      ARB_IDLE: begin
        if (i_m_access && (!d_m_access || last_owner == ARB_GRANT_D)) begin
          owner_nxt      = ARB_GRANT_I;
          last_owner_nxt = ARB_GRANT_I;
          burst_nxt      = i_line_fill;
          burst_cnt_nxt  = '0;
        end else if (d_m_access) begin
          owner_nxt      = ARB_GRANT_D;
          last_owner_nxt = ARB_GRANT_D;
          burst_nxt      = 1'b0;
        end
      end
      ARB_GRANT_I: begin
        if (q_m_ack) begin
          if (!burst) begin
            owner_nxt = ARB_IDLE;
          end else if (burst_cnt == CNT_LAST) begin
            owner_nxt     = ARB_IDLE;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end
      end
      ARB_GRANT_D: begin
        if (q_m_ack) owner_nxt = ARB_IDLE;
      end
      default: owner_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_m_access   = 1'b0;
    i_m_ack      = 1'b0;
    d_m_ack      = 1'b0;
    i_m_data_in  = q_m_data_in;
    d_m_data_in  = q_m_data_in;
    case (owner)
      ARB_GRANT_I: begin
        q_m_addr    = i_m_addr;
        q_m_bytesel = 2'b11;
        q_m_access  = i_m_access;
        i_m_ack     = q_m_ack;
      end
      ARB_GRANT_D: begin
        q_m_addr     = d_m_addr;
        q_m_data_out = d_m_data_out;
        q_m_wr_en    = d_m_wr_en;
        q_m_bytesel  = d_m_bytesel;
        q_m_access   = d_m_access;
        d_m_ack      = q_m_ack;
      end
      default: ;
    endcase
  end

`ifdef ICACHE_COHERENCE_INVAL_EN
  // Writes are single-word and separated by IDLE, so one register stage suffices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inval_valid <= 1'b0;
      inval_addr  <= '0;
    end else begin
      inval_valid <= (owner == ARB_GRANT_D) && d_m_wr_en && q_m_ack;
      if ((owner == ARB_GRANT_D) && d_m_wr_en && q_m_ack) inval_addr <= d_m_addr;
    end
  end
`else
  assign inval_valid = 1'b0;
  assign inval_addr  = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; inputs change on the falling edge.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  word_addr_t  i_m_addr;
  logic        i_m_access, i_line_fill;
  logic [15:0] i_m_data_in;
  logic        i_m_ack;
  word_addr_t  d_m_addr;
  logic [15:0] d_m_data_out;
  logic        d_m_wr_en;
  logic [1:0]  d_m_bytesel;
  logic        d_m_access;
  logic [15:0] d_m_data_in;
  logic        d_m_ack;
  word_addr_t  q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_access;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;
  logic        inval_valid;
  word_addr_t  inval_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_WORDS(8)) dut (
    .clk(clk), .reset(reset),
    .i_m_addr(i_m_addr), .i_m_access(i_m_access), .i_line_fill(i_line_fill),
    .i_m_data_in(i_m_data_in), .i_m_ack(i_m_ack),
    .d_m_addr(d_m_addr), .d_m_data_out(d_m_data_out), .d_m_wr_en(d_m_wr_en),
    .d_m_bytesel(d_m_bytesel), .d_m_access(d_m_access),
    .d_m_data_in(d_m_data_in), .d_m_ack(d_m_ack),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_m_access(q_m_access), .q_m_ack(q_m_ack),
    .q_m_data_in(q_m_data_in), .inval_valid(inval_valid), .inval_addr(inval_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Grant is taken on the next edge; q_m_access must stay low in the request cycle.
  task automatic start_i(input word_addr_t addr, input logic fill);
    i_m_addr = addr; i_line_fill = fill; i_m_access = 1'b1;
    #1 chk("req_cycle_no_access", 32'(q_m_access), 32'd0);
    step(); #1;
    chk("i_grant_access", 32'(q_m_access), 32'd1);
    chk("i_grant_bytesel", 32'(q_m_bytesel), 32'd3);
    chk("i_grant_addr", 32'(q_m_addr), 32'(addr));
  endtask

  // n acked words with a one-cycle access gap after each; owner checked in every gap.
  task automatic fill_words(input int n, input bit inject_d);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        step(); i_m_access = 1'b1;
      end
      q_m_ack = 1'b1; q_m_data_in = 16'hA000 + 16'(k);
      if (inject_d && k == 2) begin
        d_m_access = 1'b1; d_m_addr = 19'h2_0000; d_m_wr_en = 1'b0; d_m_bytesel = 2'b10;
      end
      #1;
      chk("fill_i_ack", 32'(i_m_ack), 32'd1);
      chk("fill_d_ack_low", 32'(d_m_ack), 32'd0);
      chk("fill_i_data", 32'(i_m_data_in), 32'hA000 + 32'(k));
      chk("fill_bytesel", 32'(q_m_bytesel), 32'd3);
      step(); q_m_ack = 1'b0; i_m_access = 1'b0; #1;
      chk("fill_gap_owner", 32'(dut.owner), (k < 7) ? 32'(ARB_GRANT_I) : 32'(ARB_IDLE));
      chk("fill_gap_d_ack", 32'(d_m_ack), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_m_addr = '0; i_m_access = 1'b0; i_line_fill = 1'b0;
    d_m_addr = '0; d_m_data_out = '0; d_m_wr_en = 1'b0; d_m_bytesel = 2'b00; d_m_access = 1'b0;
    q_m_ack = 1'b0; q_m_data_in = 16'h5A5A;
    step(); step(); #1;
    chk("rst_q_access", 32'(q_m_access), 32'd0);
    chk("rst_q_bytesel", 32'(q_m_bytesel), 32'd0);
    chk("rst_inval", 32'(inval_valid), 32'd0);
    chk("rst_passthru", 32'(d_m_data_in), 32'h5A5A);
    step(); reset = 1'b0;

    // Lone fill with a data request arriving during word 3
    step();
    start_i(19'h00100, 1'b1);
    fill_words(8, 1'b1);
    chk("idle_gap_access", 32'(q_m_access), 32'd0);
    step(); #1;
    chk("d_grant_owner", 32'(dut.owner), 32'(ARB_GRANT_D));
    chk("d_grant_addr", 32'(q_m_addr), 32'h2_0000);
    chk("d_grant_bytesel", 32'(q_m_bytesel), 32'd2);
    chk("d_ack_before", 32'(d_m_ack), 32'd0);
    q_m_ack = 1'b1; #1;
    chk("d_ack", 32'(d_m_ack), 32'd1);
    chk("d_ack_i_low", 32'(i_m_ack), 32'd0);
    step(); q_m_ack = 1'b0; d_m_access = 1'b0; #1;
    chk("d_done_owner", 32'(dut.owner), 32'(ARB_IDLE));

    // Single-word I read with line fill disabled
    step();
    start_i(19'h00777, 1'b0);
    q_m_ack = 1'b1; #1;
    chk("bypass_ack", 32'(i_m_ack), 32'd1);
    step(); q_m_ack = 1'b0; i_m_access = 1'b0; #1;
    chk("bypass_owner", 32'(dut.owner), 32'(ARB_IDLE));
    chk("bypass_cnt", 32'(dut.burst_cnt), 32'd0);

    // Data write and coherence invalidate
    step();
    d_m_addr = 19'h0_1234; d_m_data_out = 16'hBEEF; d_m_wr_en = 1'b1;
    d_m_bytesel = 2'b01; d_m_access = 1'b1;
    step(); #1;
    chk("wr_en", 32'(q_m_wr_en), 32'd1);
    chk("wr_data", 32'(q_m_data_out), 32'hBEEF);
    chk("wr_bytesel", 32'(q_m_bytesel), 32'd1);
    chk("wr_no_inval_yet", 32'(inval_valid), 32'd0);
    q_m_ack = 1'b1; #1;
    chk("wr_ack", 32'(d_m_ack), 32'd1);
    step(); q_m_ack = 1'b0; d_m_access = 1'b0; d_m_wr_en = 1'b0; #1;
`ifdef ICACHE_COHERENCE_INVAL_EN
    chk("inval_pulse", 32'(inval_valid), 32'd1);
    chk("inval_addr", 32'(inval_addr), 32'h0_1234);
`else
    chk("inval_tied", 32'(inval_valid), 32'd0);
    chk("inval_addr_tied", 32'(inval_addr), 32'd0);
`endif
    step(); #1;
    chk("inval_one_cycle", 32'(inval_valid), 32'd0);

    // Async reset after 5 acks of a fill, then a fresh fill needs all 8
    start_i(19'h00200, 1'b1);
    fill_words(5, 1'b0);
    step(); i_m_access = 1'b1; #1;
    chk("pre_rst_access", 32'(q_m_access), 32'd1);
    #2 reset = 1'b1; #1;
    chk("async_rst_access", 32'(q_m_access), 32'd0);
    chk("async_rst_bytesel", 32'(q_m_bytesel), 32'd0);
    chk("async_rst_cnt", 32'(dut.burst_cnt), 32'd0);
    q_m_ack = 1'b1; #1;
    chk("async_rst_no_ack", 32'(i_m_ack), 32'd0);
    step(); reset = 1'b0; q_m_ack = 1'b0; i_m_access = 1'b0;
    step();
    start_i(19'h00300, 1'b1);
    fill_words(8, 1'b0);

    // Round-robin ties after reset
    step(); reset = 1'b1; step(); reset = 1'b0;
    step();
    i_m_addr = 19'h00ABC; i_line_fill = 1'b0; i_m_access = 1'b1;
    d_m_addr = 19'h05555; d_m_bytesel = 2'b11; d_m_access = 1'b1;
    step(); #1;
    chk("tie1_addr", 32'(q_m_addr), 32'h00ABC);
    q_m_ack = 1'b1; #1;
    chk("tie1_i_ack", 32'(i_m_ack), 32'd1);
    step(); #1;
    chk("idle_ack_ignored_i", 32'(i_m_ack), 32'd0);
    chk("idle_ack_ignored_d", 32'(d_m_ack), 32'd0);
    q_m_ack = 1'b0;
    step(); #1;
    chk("tie2_owner", 32'(dut.owner), 32'(ARB_GRANT_D));
    chk("tie2_addr", 32'(q_m_addr), 32'h05555);
    q_m_ack = 1'b1; #1;
    chk("tie2_d_ack", 32'(d_m_ack), 32'd1);
    step(); q_m_ack = 1'b0;
    step(); #1;
    chk("tie3_owner", 32'(dut.owner), 32'(ARB_GRANT_I));
    chk("tie3_addr", 32'(q_m_addr), 32'h00ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
